// File: rtl/reg_bank_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_ctrl_pkg
// Description : Shared types and default sizes for the register-bank
//               initiator and its write-back queue.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_ctrl_pkg;

    localparam int C_WORD_W   = 16;
    localparam int C_ADDR_W   = 3;
    localparam int C_WB_DEPTH = 2;

    typedef logic [C_WORD_W-1:0] word_t;
    typedef logic [C_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } bank_op_t;

endpackage
`default_nettype wire

// File: rtl/reg_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_ctrl_if
// Description : Request, response, write-back and bank-side signals of the
//               register-bank initiator. slave = controller view,
//               master = requester/bank view.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_ctrl_if
    import reg_bank_ctrl_pkg::*;
#(
    parameter int WORD_W = C_WORD_W,
    parameter int ADDR_W = C_ADDR_W
) ();

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_a;
    logic [WORD_W-1:0] rsp_b;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [WORD_W-1:0] wb_data;
    logic              bk_hab_escrita;
    logic [ADDR_W-1:0] bk_sel_e_sa;
    logic [ADDR_W-1:0] bk_sel_sb;
    logic [WORD_W-1:0] bk_e;
    logic [WORD_W-1:0] bk_a;
    logic [WORD_W-1:0] bk_b;

    modport slave (
        input  rd_valid, rd_addr_a, rd_addr_b, rsp_ready,
        input  wb_valid, wb_addr, wb_data, bk_a, bk_b,
        output rd_ready, rsp_valid, rsp_a, rsp_b, wb_ready,
        output bk_hab_escrita, bk_sel_e_sa, bk_sel_sb, bk_e
    );

    modport master (
        output rd_valid, rd_addr_a, rd_addr_b, rsp_ready,
        output wb_valid, wb_addr, wb_data, bk_a, bk_b,
        input  rd_ready, rsp_valid, rsp_a, rsp_b, wb_ready,
        input  bk_hab_escrita, bk_sel_e_sa, bk_sel_sb, bk_e
    );

endinterface
`default_nettype wire

// File: rtl/reg_bank_ctrl_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : In-order write-back FIFO. Entry 0 is always the head; a pop
//               shifts the entries down. Two lookup ports return the
//               youngest queued entry matching an address.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue
    import reg_bank_ctrl_pkg::*;
#(
    parameter int WORD_W = C_WORD_W,
    parameter int ADDR_W = C_ADDR_W,
    parameter int DEPTH  = C_WB_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [WORD_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] lk_addr_a,
    output logic              lk_hit_a,
    output logic [WORD_W-1:0] lk_data_a,
    input  logic [ADDR_W-1:0] lk_addr_b,
    output logic              lk_hit_b,
    output logic [WORD_W-1:0] lk_data_b
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [WORD_W-1:0] r_data [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_push_idx;

    // With a simultaneous pop the push lands one slot lower (the freed slot).
    assign w_push_idx = pop ? (r_count - CNT_W'(1)) : r_count;
    assign full       = (r_count == CNT_W'(DEPTH));
    assign empty      = (r_count == '0);
    assign head_addr  = r_addr[0];
    assign head_data  = r_data[0];

    // Entry storage: shift toward the head on pop, insert at the tail on push.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (w_push_idx == CNT_W'(i))) begin
                r_addr[i] <= push_addr;
                r_data[i] <= push_data;
            end else if (pop) begin
                r_addr[i] <= r_addr[(i + 1 < DEPTH) ? i + 1 : i];
                r_data[i] <= r_data[(i + 1 < DEPTH) ? i + 1 : i];
            end
        end
    end

    // Occupancy counter; reset discards everything queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Youngest-match lookup: later (younger) entries override earlier ones.
    always_comb begin
        lk_hit_a  = 1'b0;
        lk_data_a = '0;
        lk_hit_b  = 1'b0;
        lk_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < r_count) begin
                if (r_addr[i] == lk_addr_a) begin
                    lk_hit_a  = 1'b1;
                    lk_data_a = r_data[i];
                end
                if (r_addr[i] == lk_addr_b) begin
                    lk_hit_b  = 1'b1;
                    lk_data_b = r_data[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_ctrl
// Description : Initiator for the 8x16 register bank. Serialises operand
//               reads and queued write-backs onto the bank's single port,
//               bypassing queued data so reads always see the latest value.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_ctrl
    import reg_bank_ctrl_pkg::*;
#(
    parameter int WORD_W   = C_WORD_W,
    parameter int ADDR_W   = C_ADDR_W,
    parameter int WB_DEPTH = C_WB_DEPTH
) (
    input  logic           clock,
    input  logic           reset,
    reg_bank_ctrl_if.slave bus
);

    state_t            r_state;
    state_t            w_state_next;
    bank_op_t          w_op;
    logic              w_rd_ready;
    logic              w_wb_ready;
    logic              w_rd_acc;
    logic              w_wb_acc;
    logic              w_pop;
    logic              w_q_full;
    logic              w_q_empty;
    logic [ADDR_W-1:0] w_head_addr;
    logic [WORD_W-1:0] w_head_data;
    logic              w_lk_hit_a;
    logic              w_lk_hit_b;
    logic [WORD_W-1:0] w_lk_data_a;
    logic [WORD_W-1:0] w_lk_data_b;
    logic              r_ovr_hit_a;
    logic              r_ovr_hit_b;
    logic [WORD_W-1:0] r_ovr_data_a;
    logic [WORD_W-1:0] r_ovr_data_b;
    logic [WORD_W-1:0] r_rsp_a;
    logic [WORD_W-1:0] r_rsp_b;
    logic              r_bk_hab;
    logic [ADDR_W-1:0] r_bk_sel_e_sa;
    logic [ADDR_W-1:0] r_bk_sel_sb;
    logic [WORD_W-1:0] r_bk_e;

    // A full queue blocks reads so writes always get bank cycles.
    assign w_rd_ready = !reset && (r_state == S_IDLE) && !w_q_full;
    assign w_wb_ready = !reset && !w_q_full;
    assign w_rd_acc   = bus.rd_valid && w_rd_ready;
    assign w_wb_acc   = bus.wb_valid && w_wb_ready;
    assign w_pop      = (w_op == OP_WRITE) && !reset;

    assign bus.rd_ready       = w_rd_ready;
    assign bus.wb_ready       = w_wb_ready;
    assign bus.rsp_valid      = (r_state == S_RESP);
    assign bus.rsp_a          = r_rsp_a;
    assign bus.rsp_b          = r_rsp_b;
    assign bus.bk_hab_escrita = r_bk_hab;
    assign bus.bk_sel_e_sa    = r_bk_sel_e_sa;
    assign bus.bk_sel_sb      = r_bk_sel_sb;
    assign bus.bk_e           = r_bk_e;

    wb_queue #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WB_DEPTH)
    ) u_wb_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (w_wb_acc),
        .push_addr (bus.wb_addr),
        .push_data (bus.wb_data),
        .pop       (w_pop),
        .head_addr (w_head_addr),
        .head_data (w_head_data),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .lk_addr_a (bus.rd_addr_a),
        .lk_hit_a  (w_lk_hit_a),
        .lk_data_a (w_lk_data_a),
        .lk_addr_b (bus.rd_addr_b),
        .lk_hit_b  (w_lk_hit_b),
        .lk_data_b (w_lk_data_b)
    );

    // One bank op per cycle: a read issue wins over draining the queue.
    always_comb begin
        w_op = OP_IDLE;
        if (w_rd_acc) begin
            w_op = OP_READ;
        end else if (!w_q_empty) begin
            w_op = OP_WRITE;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept -> capture -> hold response until consumed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_rd_acc) w_state_next = S_CAPT;
            S_CAPT:  w_state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latch bypass overrides at accept; merge with bank data at capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovr_hit_a  <= 1'b0;
            r_ovr_hit_b  <= 1'b0;
            r_ovr_data_a <= '0;
            r_ovr_data_b <= '0;
            r_rsp_a      <= '0;
            r_rsp_b      <= '0;
        end else begin
            if (w_rd_acc) begin
                r_ovr_hit_a  <= w_lk_hit_a;
                r_ovr_hit_b  <= w_lk_hit_b;
                r_ovr_data_a <= w_lk_data_a;
                r_ovr_data_b <= w_lk_data_b;
            end
            if (r_state == S_CAPT) begin
                r_rsp_a <= r_ovr_hit_a ? r_ovr_data_a : bus.bk_a;
                r_rsp_b <= r_ovr_hit_b ? r_ovr_data_b : bus.bk_b;
            end
        end
    end

    // Registered bank port; selects and data hold their value on idle cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bk_hab      <= 1'b0;
            r_bk_sel_e_sa <= '0;
            r_bk_sel_sb   <= '0;
            r_bk_e        <= '0;
        end else begin
            case (w_op)
                OP_READ: begin
                    r_bk_hab      <= 1'b0;
                    r_bk_sel_e_sa <= bus.rd_addr_a;
                    r_bk_sel_sb   <= bus.rd_addr_b;
                end
                OP_WRITE: begin
                    r_bk_hab      <= 1'b1;
                    r_bk_sel_e_sa <= w_head_addr;
                    r_bk_e        <= w_head_data;
                end
                default: begin
                    r_bk_hab <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_ctrl
// Description : Self-checking bench for reg_bank_ctrl with a behavioural
//               register bank and an architectural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_ctrl;

    localparam int WW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2;

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } wbe_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    reg_bank_ctrl_if #(.WORD_W(WW), .ADDR_W(AW)) bus ();

    reg_bank_ctrl #(
        .WORD_W   (WW),
        .ADDR_W   (AW),
        .WB_DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural bank: acts on the negedge, outputs sampled at next posedge.
    logic [WW-1:0] mem [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                               16'h0004, 16'h0005, 16'h0006, 16'h0007};

    always @(negedge clock) begin
        if (bus.bk_hab_escrita === 1'b1) mem[bus.bk_sel_e_sa] <= bus.bk_e;
        bus.bk_a <= mem[bus.bk_sel_e_sa];
        bus.bk_b <= mem[bus.bk_sel_sb];
    end

    // Reference model: committed bank image plus pending write-backs in order.
    logic [WW-1:0] committed [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                     16'h0004, 16'h0005, 16'h0006, 16'h0007};
    wbe_t          mq [$];
    int            phase = 0;   // 0 idle, 1 waiting for capture, 2 response held
    logic [WW-1:0] exp_a;
    logic [WW-1:0] exp_b;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] arch_val(input logic [AW-1:0] a);
        logic [WW-1:0] v;
        v = committed[a];
        foreach (mq[i]) if (mq[i].a == a) v = mq[i].d;
        return v;
    endfunction

    task automatic step(input logic rst, input logic rv, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input logic rr, input logic wv,
                        input logic [AW-1:0] wa, input logic [WW-1:0] wd);
        logic exp_rdy, exp_wbr, rd_acc, wb_acc, rsp_acc, popped;
        wbe_t pe;
        reset         = rst;
        bus.rd_valid  = rv;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        bus.rsp_ready = rr;
        bus.wb_valid  = wv;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        #1;
        exp_wbr = !rst && (mq.size() < DEPTH);
        exp_rdy = exp_wbr && (phase == 0);
        chk("rd_ready", bus.rd_ready, exp_rdy);
        chk("wb_ready", bus.wb_ready, exp_wbr);
        rd_acc  = rv && exp_rdy;
        wb_acc  = wv && exp_wbr;
        rsp_acc = (phase == 2) && rr;
        popped  = 1'b0;
        pe      = '{a: '0, d: '0};
        @(posedge clock);
        #1;
        if (rst) begin
            phase = 0;
            mq.delete();
        end else begin
            if (rd_acc) begin
                exp_a = arch_val(ra);
                exp_b = arch_val(rb);
            end else if (mq.size() > 0) begin
                pe = mq.pop_front();
                committed[pe.a] = pe.d;
                popped = 1'b1;
            end
            if (wb_acc) mq.push_back('{a: wa, d: wd});
            case (phase)
                0: if (rd_acc) phase = 1;
                1: phase = 2;
                default: if (rsp_acc) phase = 0;
            endcase
        end
        chk("rsp_valid", bus.rsp_valid, phase == 2);
        if (phase == 2) begin
            chk("rsp_a", bus.rsp_a, exp_a);
            chk("rsp_b", bus.rsp_b, exp_b);
        end
        if (rst) begin
            chk("rst_rsp_a", bus.rsp_a, 0);
            chk("rst_rsp_b", bus.rsp_b, 0);
            chk("rst_hab", bus.bk_hab_escrita, 0);
            chk("rst_sel_e_sa", bus.bk_sel_e_sa, 0);
            chk("rst_sel_sb", bus.bk_sel_sb, 0);
            chk("rst_bk_e", bus.bk_e, 0);
        end else if (rd_acc) begin
            chk("rdop_hab", bus.bk_hab_escrita, 0);
            chk("rdop_sel_a", bus.bk_sel_e_sa, ra);
            chk("rdop_sel_b", bus.bk_sel_sb, rb);
        end else if (popped) begin
            chk("wrop_hab", bus.bk_hab_escrita, 1);
            chk("wrop_sel", bus.bk_sel_e_sa, pe.a);
            chk("wrop_data", bus.bk_e, pe.d);
        end else begin
            chk("idle_hab", bus.bk_hab_escrita, 0);
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, '0, '0, rr, 1'b0, '0, '0);
    endtask

    initial begin
        // Reset
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

        // Write-back r3, then read a=r3 b=r0 from the bank
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 3'd3, 16'h1234);
        repeat (3) idle(1'b1);
        step(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        chk("t1_rsp_a", bus.rsp_a, 16'h1234);
        chk("t1_rsp_b", bus.rsp_b, 16'h0000);
        idle(1'b1);

        // Back-to-back write-backs to r5, read via bypass
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 3'd5, 16'hAAAA);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 3'd5, 16'h5555);
        step(1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        chk("t2_rsp_a", bus.rsp_a, 16'h5555);
        idle(1'b1);
        repeat (2) idle(1'b1);
        chk("t2_bank_r5", mem[5], 16'h5555);

        // Fill the queue while the response is held
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 3'd2, 16'h2222);
        step(1'b0, 1'b1, 3'd2, 3'd4, 1'b0, 1'b1, 3'd4, 16'h4444);
        chk("t3_wb_ready_full", bus.wb_ready, 0);
        chk("t3_rd_ready_full", bus.rd_ready, 0);
        idle(1'b0);
        idle(1'b0);
        chk("t3_rsp_a", bus.rsp_a, 16'h2222);
        chk("t3_rsp_b", bus.rsp_b, 16'h0004);
        idle(1'b1);
        repeat (2) idle(1'b1);
        chk("t3_bank_r2", mem[2], 16'h2222);
        chk("t3_bank_r4", mem[4], 16'h4444);

        // Same-edge read and write-back to r1
        step(1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b1, 3'd1, 16'h0F0F);
        idle(1'b0);
        chk("t4_rsp_a_old", bus.rsp_a, 16'h0001);
        idle(1'b1);
        step(1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        chk("t4_rsp_a_new", bus.rsp_a, 16'h0F0F);
        idle(1'b1);

        // Response held for 5 cycles
        step(1'b0, 1'b1, 3'd6, 3'd7, 1'b0, 1'b0, '0, '0);
        repeat (5) idle(1'b0);
        idle(1'b1);

        // Reset in S_CAPT with two queued writes
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 3'd6, 16'h6666);
        step(1'b0, 1'b1, 3'd0, 3'd1, 1'b0, 1'b1, 3'd7, 16'h7777);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (3) idle(1'b1);
        chk("t6_bank_r6", mem[6], 16'h0006);
        chk("t6_bank_r7", mem[7], 16'h0007);

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                 AW'($urandom), AW'($urandom), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 1) == 1), AW'($urandom), WW'($urandom));
        end

        // Drain and compare the bank image
        repeat (6) idle(1'b1);
        for (int i = 0; i < 8; i++) chk("final_bank", mem[i], committed[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
